// File: rtl/pc_fetch_unit.sv
// Program-counter and fetch front end: owns pc, fetches over req/ack, holds instr, counts retires.
// Latency: 2 cycles per instruction minimum (FETCH with same-cycle ack, then one EXEC cycle).
// Backpressure: FETCH holds req/addr until ack; stall holds EXEC with no pc/instret update.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  PC_Sel,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        branch_taken,
  input  logic [31:0] target_pcimm,
  input  logic [31:0] target_jalr,
  input  logic        endProgram,
  input  logic        stall,
  output logic        halted,
  output logic        misaligned,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic        halted_q, halted_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] next_pc;

  // Outputs are pure decodes of registered state; only rst gates the request.
  assign imem_req    = (state_q == S_FETCH) && !rst;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_EXEC);
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign halted      = halted_q;
  assign misaligned  = misaligned_q;
  assign instret     = instret_q;

  // Next-PC mux; PC_Sel=11 is the halt encoding and is handled by the FSM.
  always_comb begin
    next_pc = pc_plus4;
    case (PC_Sel)
      2'b01: begin
        if (Jump || (Branch && branch_taken)) begin
          next_pc = target_pcimm;
        end
      end
      2'b10:   next_pc = {target_jalr[31:1], 1'b0};
      default: next_pc = pc_plus4;
    endcase
  end

  // FSM next-state plus pc/instr/instret/halt-flag updates.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instret_d    = instret_q;
    halted_d     = halted_q;
    misaligned_d = misaligned_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          if (endProgram || (PC_Sel == 2'b11)) begin
            // The halting instruction itself retires.
            state_d   = S_HALT;
            halted_d  = 1'b1;
            instret_d = instret_q + 32'd1;
          end else if (next_pc[1:0] != 2'b00) begin
            // Faulting control transfer does not retire; pc keeps the culprit.
            state_d      = S_HALT;
            halted_d     = 1'b1;
            misaligned_d = 1'b1;
          end else begin
            pc_d      = next_pc;
            instret_d = instret_q + 32'd1;
            state_d   = S_FETCH;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      instret_q    <= 32'd0;
      halted_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instret_q    <= instret_d;
      halted_q     <= halted_d;
      misaligned_q <= misaligned_d;
    end
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Sequential front end of the femtoRV32 core: owns the program counter, fetches each instruction from instruction memory over a req/ack handshake, and holds it in an instruction register. The control unit decodes that register (Opcode = instr[6:2], Funct3 = instr[14:12]). The control unit's PC_Sel/endProgram decisions, together with branch resolution, are consumed here to pick the next PC or halt the core. The block also keeps a retired-instruction counter.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset
- NOP_INSTR, 32'h0000_0013, instr value after reset (addi x0,x0,0)
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request, high only in FETCH and only while rst=0
- imem_addr  out  32  equals pc whenever imem_req=1
- imem_ack  in  1  read data valid this cycle; ignored unless imem_req=1
- imem_rdata  in  32  fetched instruction word
- instr  out  32  instruction register, feeds decode
- instr_valid  out  1  high in EXEC: instr is being executed this cycle
- pc  out  32  address of instr
- pc_plus4  out  32  pc + 4 mod 2^32, for write-back of return address
- PC_Sel  in  2  from control unit: 00 PC+4, 01 PC+imm, 10 rs1+imm, 11 halt
- Jump  in  1  from control unit
- Branch  in  1  from control unit
- branch_taken  in  1  branch condition result from the ALU flags
- target_pcimm  in  32  pc + imm
- target_jalr  in  32  rs1 + imm (LSB cleared here)
- endProgram  in  1  from control unit
- stall  in  1  hold EXEC; no PC update, no retire
- halted  out  1  core stopped, sticky until rst
- misaligned  out  1  halt cause: next PC not word aligned, sticky until rst
- instret  out  32  retired instruction count

## Operation
- States: FETCH, EXEC, HALT. Reset → FETCH.
- Reset values: pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, imem_req=0, halted=0, misaligned=0, instret=0. pc_plus4 is always pc+4.
- FETCH: imem_req=1 and imem_addr=pc. When imem_ack=1, instr<=imem_rdata and the state goes to EXEC. Otherwise the state stays in FETCH with req and addr held stable.
- EXEC: instr_valid=1. If stall=1, the state stays in EXEC and pc, instr and instret are unchanged.
- EXEC with stall=0, next-PC selection:
  - endProgram=1 or PC_Sel=11: pc unchanged, state goes to HALT, halted<=1; instret increments (the halting instruction retires).
  - PC_Sel=00: next = pc+4.
  - PC_Sel=01: next = target_pcimm if Jump=1 or (Branch=1 and branch_taken=1). Otherwise next = pc+4.
  - PC_Sel=10: next = {target_jalr[31:1],1'b0}.
  - If next[1:0]≠00: pc unchanged, state goes to HALT, halted<=1, misaligned<=1; instret does not increment.
  - Otherwise pc<=next, instret<=instret+1, state goes to FETCH.
- HALT: imem_req=0, instr_valid=0. The block stays in HALT until rst, and all inputs are ignored.
- Arithmetic: pc+4 and instret wrap modulo 2^32 with no flag. A PC wrap from 32'hFFFF_FFFC to 0 is legal.
- rst has priority in every state. A pending or same-cycle imem_ack is discarded, and the next cycle is FETCH at RESET_PC.

## Timing
- Minimum of 2 cycles per instruction: a FETCH cycle with same-cycle ack, then one EXEC cycle. Each cycle of ack delay adds 1 cycle, and each stall cycle adds 1 cycle.
- imem_req rises in the first cycle after rst falls.
- imem_req, imem_addr, instr_valid and halted are registered-state decodes, with no combinational path from imem_ack.
- A new pc is visible the cycle after its EXEC cycle, in the same cycle that FETCH requests it.
- The halted output rises the cycle after the halting EXEC cycle.

## Test plan
- Reset then fetch: hold rst for 2 cycles, then use a 0-wait memory. Required: imem_req=1 at addr 0 in cycle 1; instr_valid in cycle 2; pc=4 in cycle 3; after 3 addi instructions, instret=3.
- Wait states plus stall: ack delayed 3 cycles, then stall=1 for 2 EXEC cycles. Required: imem_addr held during the wait, instr latched only on ack, pc/instret frozen during the stall, and 7 cycles total for that instruction.
- Branch and jumps:
  - At pc=0x10, beq with branch_taken=0 → next pc 0x14.
  - beq with branch_taken=1 and target 0x40 → next pc 0x40.
  - jal to 0x100 → next pc 0x100.
  - jalr with target_jalr=0x205 → next pc 0x204.
- Halt: ecall at pc=0x20 (PC_Sel=11, endProgram=1). Required: halted=1 next cycle, pc stays 0x20, instret+1, imem_req stays 0 for 10 cycles despite input toggling.
- Misalignment: jal with target_pcimm=0x102. Required: halted=1, misaligned=1, pc unchanged, instret unchanged.
- Reset mid-fetch: assert rst in the cycle imem_ack=1 with rdata=0xDEADBEEF. Required: instr=NOP_INSTR, pc=RESET_PC, then a clean fetch from RESET_PC.
